// File: rtl/muldiv_hilo_if.sv
// Request/result bundle between the execute stage and the mul/div HI/LO unit.
// master: execute stage (issues ops, reads HI/LO, honours stall).
// slave:  muldiv_hilo_unit.
interface muldiv_hilo_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             rd_hilo;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             stall;

  modport master (
    output start, op, x, y, rd_hilo,
    input  hi, lo, busy, done, stall
  );

  modport slave (
    input  start, op, x, y, rd_hilo,
    output hi, lo, busy, done, stall
  );
endinterface

// File: rtl/muldiv_hilo_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// One radix-2 step per cycle: shift-add multiply, restoring shift-subtract divide.
// Optional feature macro: MULDIV_SIGNED_EN -- when defined, ops 3/4 are signed
// MULT/DIV (operand magnitudes at issue, sign fixup in FIX); otherwise ops 3/4
// behave as the unsigned ops 1/2 and no sign logic is built.
module muldiv_hilo_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  muldiv_hilo_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             is_div;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;

  // Iteration registers: acc_hi = partial product high / remainder,
  // acc_lo = multiplier being consumed / dividend shifting into quotient.
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] opnd;

  logic             op_mul;
  logic             op_div;
  logic             op_go;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_trial;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

`ifdef MULDIV_SIGNED_EN
  logic             op_sgn;
  logic             neg_q;
  logic             neg_r;
  logic             div0;

  function automatic logic [WIDTH-1:0] mag_w(input logic signed [WIDTH-1:0] v);
    // Most negative value maps onto itself, which is its correct unsigned magnitude.
    return (v < 0) ? $unsigned(-v) : $unsigned(v);
  endfunction

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + 1'b1;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
    return ~v + 1'b1;
  endfunction
`endif

  assign op_mul = (bus.op == 3'd1) || (bus.op == 3'd3);
  assign op_div = (bus.op == 3'd2) || (bus.op == 3'd4);
  assign op_go  = bus.start && (op_mul || op_div);
`ifdef MULDIV_SIGNED_EN
  assign op_sgn = (bus.op == 3'd3) || (bus.op == 3'd4);
`endif

  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
  assign div_trial = {acc_hi, acc_lo[WIDTH-1]} - {1'b0, opnd};

  assign bus.hi    = hi_r;
  assign bus.lo    = lo_r;
  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.stall = busy_r & ((bus.start & (bus.op != 3'd0) & (bus.op != 3'd7)) | bus.rd_hilo);

  // Final HI/LO values from the iteration registers, with sign fixup when built.
  always_comb begin
    res_hi = acc_hi;
    res_lo = acc_lo;
`ifdef MULDIV_SIGNED_EN
    if (!is_div) begin
      if (neg_q) {res_hi, res_lo} = neg_2w({acc_hi, acc_lo});
    end else begin
      if (neg_q && !div0) res_lo = neg_w(acc_lo);
      if (neg_r)          res_hi = neg_w(acc_hi);
    end
`endif
  end

  // Datapath: load operands at issue, then one shift-add / shift-subtract step per RUN cycle.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && op_go) begin
      acc_hi <= '0;
`ifdef MULDIV_SIGNED_EN
      acc_lo <= op_sgn ? mag_w(bus.x) : bus.x;
      opnd   <= op_sgn ? mag_w(bus.y) : bus.y;
      neg_q  <= op_sgn & (bus.x[WIDTH-1] ^ bus.y[WIDTH-1]);
      neg_r  <= op_sgn & bus.x[WIDTH-1];
      div0   <= (bus.y == '0);
`else
      acc_lo <= bus.x;
      opnd   <= bus.y;
`endif
    end else if (state == S_RUN) begin
      if (!is_div) begin
        acc_hi <= mul_sum[WIDTH:1];
        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
      end else if (!div_trial[WIDTH]) begin
        acc_hi <= div_trial[WIDTH-1:0];
        acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        acc_hi <= {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
        acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Control FSM with registered busy/done and the architectural HI/LO registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (op_go) begin
            state  <= S_RUN;
            cnt    <= '0;
            is_div <= op_div;
            busy_r <= 1'b1;
          end else if (bus.start && bus.op == 3'd5) begin
            hi_r <= bus.x;
          end else if (bus.start && bus.op == 3'd6) begin
            lo_r <= bus.x;
          end
        end
        S_RUN: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) state <= S_FIX;
        end
        S_FIX: begin
          state  <= S_IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b1;
          hi_r   <= res_hi;
          lo_r   <= res_lo;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Directed bench for muldiv_hilo_unit with a {hi,lo} scoreboard queue.
module tb_muldiv_hilo_unit;

  logic clk = 1'b0;
  logic rst_n;

  muldiv_hilo_if #(.WIDTH(32)) bus_i ();

  muldiv_hilo_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_i)
  );

  always #5 clk = ~clk;

  int          tests_run = 0;
  int          failed    = 0;
  int          lat       = 0;
  logic [63:0] sb_q[$];

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] r;
    logic        sgn;
    longint      sa, sb, q, m;
    sgn = 1'b0;
`ifdef MULDIV_SIGNED_EN
    sgn = (op == 3'd3) || (op == 3'd4);
`endif
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == 3'd1 || op == 3'd3) begin
      if (sgn) r = 64'(sa * sb);
      else     r = {32'b0, a} * {32'b0, b};
    end else if (b == 32'd0) begin
      r = {a, 32'hFFFF_FFFF};
    end else if (sgn) begin
      q = sa / sb;
      m = sa % sb;
      r = {m[31:0], q[31:0]};
    end else begin
      r = {a % b, a / b};
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
    lat++;
  endtask

  // Drive a one-cycle request; returns one negedge after the issue edge (lat = 1).
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit push);
    bus_i.start = 1'b1;
    bus_i.op    = op;
    bus_i.x     = a;
    bus_i.y     = b;
    if (push) sb_q.push_back(model(op, a, b));
    lat = 0;
    tick();
    bus_i.start = 1'b0;
    bus_i.op    = 3'd0;
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    logic [63:0] e;
    while (!bus_i.done && lat < 200) tick();
    check({tag, " done"}, 64'(bus_i.done), 64'd1);
    check({tag, " latency"}, 64'(lat - 1), 64'(exp_lat));
    check({tag, " busy low at done"}, 64'(bus_i.busy), 64'd0);
    check({tag, " sb nonempty"}, 64'(sb_q.size() != 0), 64'd1);
    e = (sb_q.size() != 0) ? sb_q.pop_front() : 64'hx;
    check({tag, " hilo"}, {bus_i.hi, bus_i.lo}, e);
  endtask

  initial begin
    logic [31:0] ph, pl;
    int          ndone;
    rst_n         = 1'b0;
    bus_i.start   = 1'b0;
    bus_i.op      = 3'd0;
    bus_i.x       = '0;
    bus_i.y       = '0;
    bus_i.rd_hilo = 1'b0;
    tick();
    tick();
    check("reset hi", 64'(bus_i.hi), 64'd0);
    check("reset lo", 64'(bus_i.lo), 64'd0);
    check("reset busy", 64'(bus_i.busy), 64'd0);
    check("reset done", 64'(bus_i.done), 64'd0);
    rst_n = 1'b1;
    tick();

    // MTHI then MTLO back-to-back
    bus_i.start = 1'b1;
    bus_i.op    = 3'd5;
    bus_i.x     = 32'hA5A5_A5A5;
    tick();
    check("mthi hi", 64'(bus_i.hi), 64'hA5A5_A5A5);
    check("mthi lo", 64'(bus_i.lo), 64'd0);
    check("mthi busy", 64'(bus_i.busy), 64'd0);
    check("mthi done", 64'(bus_i.done), 64'd0);
    bus_i.op = 3'd6;
    bus_i.x  = 32'h5A5A_5A5A;
    tick();
    bus_i.start = 1'b0;
    bus_i.op    = 3'd0;
    check("mtlo lo", 64'(bus_i.lo), 64'h5A5A_5A5A);
    check("mtlo hi", 64'(bus_i.hi), 64'hA5A5_A5A5);
    check("mtlo busy", 64'(bus_i.busy), 64'd0);
    check("mtlo done", 64'(bus_i.done), 64'd0);

    // Reset in the middle of a MULTU
    issue(3'd1, 32'd5, 32'd7, 1'b0);
    while (lat < 10) tick();
    check("midrun busy", 64'(bus_i.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("async rst busy", 64'(bus_i.busy), 64'd0);
    check("async rst hi", 64'(bus_i.hi), 64'd0);
    check("async rst lo", 64'(bus_i.lo), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus_i.done) ndone++;
    end
    check("no done after rst", 64'(ndone), 64'd0);
    check("post rst hi", 64'(bus_i.hi), 64'd0);
    check("post rst lo", 64'(bus_i.lo), 64'd0);

    // MULTU max*max, with a NOP request while busy that must not stall
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    bus_i.start = 1'b1;
    bus_i.op    = 3'd7;
    #1;
    check("nop no stall", 64'(bus_i.stall), 64'd0);
    check("multu busy", 64'(bus_i.busy), 64'd1);
    bus_i.start = 1'b0;
    bus_i.op    = 3'd0;
    wait_done("multu max", 33);
    check("multu max const", {bus_i.hi, bus_i.lo}, 64'hFFFF_FFFE_0000_0001);
    tick();
    check("done one cycle", 64'(bus_i.done), 64'd0);

    // DIVU basic and divide by zero
    issue(3'd2, 32'd100, 32'd7, 1'b1);
    wait_done("divu 100/7", 33);
    check("divu 100/7 const", {bus_i.hi, bus_i.lo}, {32'd2, 32'd14});
    issue(3'd2, 32'd5, 32'd0, 1'b1);
    wait_done("divu 5/0", 33);
    check("divu 5/0 const", {bus_i.hi, bus_i.lo}, {32'd5, 32'hFFFF_FFFF});

    // Ops 3/4 (signed only when the feature macro is defined)
    issue(3'd3, 32'hFFFF_FFFD, 32'd4, 1'b1);
    wait_done("mult -3*4", 33);
`ifdef MULDIV_SIGNED_EN
    check("mult -3*4 const", {bus_i.hi, bus_i.lo}, 64'hFFFF_FFFF_FFFF_FFF4);
`else
    check("mult -3*4 const", {bus_i.hi, bus_i.lo}, 64'h0000_0003_FFFF_FFF4);
`endif
    issue(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_done("div -7/2", 33);
`ifdef MULDIV_SIGNED_EN
    check("div -7/2 const", {bus_i.hi, bus_i.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
`else
    check("div -7/2 const", {bus_i.hi, bus_i.lo}, 64'h0000_0001_7FFF_FFFC);
`endif
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_done("div min/-1", 33);

    // rd_hilo and a second DIVU held during busy; accepted in the done cycle
    ph = bus_i.hi;
    pl = bus_i.lo;
    issue(3'd2, 32'd1000, 32'd3, 1'b1);
    bus_i.rd_hilo = 1'b1;
    bus_i.start   = 1'b1;
    bus_i.op      = 3'd2;
    bus_i.x       = 32'd50;
    bus_i.y       = 32'd6;
    #1;
    while (!bus_i.done && lat < 200) begin
      check("held stall", 64'(bus_i.stall), 64'd1);
      check("held hilo", {bus_i.hi, bus_i.lo}, {ph, pl});
      tick();
    end
    wait_done("divu 1000/3", 33);
    check("done cycle no stall", 64'(bus_i.stall), 64'd0);
    sb_q.push_back(model(3'd2, 32'd50, 32'd6));
    lat = 0;
    tick();
    bus_i.start   = 1'b0;
    bus_i.rd_hilo = 1'b0;
    bus_i.op      = 3'd0;
    check("second accepted", 64'(bus_i.busy), 64'd1);
    wait_done("divu 50/6", 33);

    // A few random unsigned ops against the model
    for (int i = 0; i < 4; i++) begin
      issue((i % 2 == 0) ? 3'd1 : 3'd2, $urandom, $urandom_range(1, 32'hFFFF), 1'b1);
      wait_done("random op", 33);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
